// File: rtl/alu_seq_if.sv
// Operation-request bus between instruction decode (master) and the ALU
// sequencer (slave). One operation is transferred per valid/ready handshake.
//   op_valid   - operation request
//   op_ready   - sequencer can accept an operation
//   op_func    - ALU function code
//   op_rd      - destination register index
//   op_rs      - source register for ALU operand a
//   op_rt      - source register for ALU operand b
//   op_imm     - immediate mode select
//   op_imm_val - immediate value
interface alu_seq_if #(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
);
  localparam int RW = $clog2(NREGS);

  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op_func;
  logic [RW-1:0]    op_rd;
  logic [RW-1:0]    op_rs;
  logic [RW-1:0]    op_rt;
  logic             op_imm;
  logic [WIDTH-1:0] op_imm_val;

  modport master (
    output op_valid, op_func, op_rd, op_rs, op_rt, op_imm, op_imm_val,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_func, op_rd, op_rs, op_rt, op_imm, op_imm_val,
    output op_ready
  );
endinterface

// File: rtl/alu_seq.sv
// ALU operation sequencer. Accepts one operation per handshake, reads its
// operands from an internal register file, presents them to a combinational
// ALU for one cycle, then writes the ALU result and status back.
//   clk         - system clock, rising edge
//   rst_n       - synchronous active-low reset
//   op          - operation request bus (slave side)
//   alu_a/b     - ALU operands, held between operations
//   alu_imm     - ALU immediate select
//   alu_imm_val - ALU immediate value
//   alu_func    - ALU function code
//   alu_out     - ALU result (combinational from the alu_* outputs)
//   alu_status  - ALU status, stored opaquely into flags
//   flags       - alu_status captured at the last writeback
//   done        - one-cycle pulse during the writeback cycle
//   result      - alu_out captured at the last writeback
//   dbg_addr    - debug read address
//   dbg_data    - combinational register-file read at dbg_addr
//
// state  | meaning
// S_IDLE | ready for a new operation; operands read on acceptance
// S_EXEC | operands presented to the ALU, result settling
// S_WB   | done high; result/status written back at the closing edge
module alu_seq #(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_seq_if.slave                 op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [WIDTH-1:0]         alu_imm_val,
  output logic                     alu_imm,
  output logic [3:0]               alu_func,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic [7:0]               alu_status,
  output logic [7:0]               flags,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);
  localparam int RW = $clog2(NREGS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t           state;
  logic             ready_q;
  logic [RW-1:0]    rd_q;
  logic [WIDTH-1:0] rf [NREGS];

  // Register 0 is hardwired to zero on every read path.
  function automatic logic [WIDTH-1:0] reg_read(input logic [RW-1:0] idx);
    return (idx == '0) ? '0 : rf[idx];
  endfunction

  assign op.op_ready = ready_q;
  assign dbg_data    = reg_read(dbg_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ready_q     <= 1'b1;
      done        <= 1'b0;
      rd_q        <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_imm_val <= '0;
      alu_imm     <= 1'b0;
      alu_func    <= '0;
      flags       <= '0;
      result      <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (op.op_valid) begin
            alu_a       <= reg_read(op.op_rs);
            alu_b       <= reg_read(op.op_rt);
            alu_func    <= op.op_func;
            alu_imm     <= op.op_imm;
            alu_imm_val <= op.op_imm_val;
            rd_q        <= op.op_rd;
            ready_q     <= 1'b0;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          // done is registered, so raising it here makes it high during WB
          done  <= 1'b1;
          state <= S_WB;
        end
        S_WB: begin
          if (rd_q != '0) rf[rd_q] <= alu_out;
          flags   <= alu_status;
          result  <= alu_out;
          done    <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  alu_seq_if #(.NREGS(8), .WIDTH(16)) bus ();

  logic [15:0] alu_a, alu_b, alu_imm_val, alu_out, result, dbg_data;
  logic        alu_imm, done;
  logic [3:0]  alu_func;
  logic [7:0]  alu_status, flags;
  logic [2:0]  dbg_addr;

  alu_seq #(.NREGS(8), .WIDTH(16)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (bus),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_imm_val (alu_imm_val),
    .alu_imm     (alu_imm),
    .alu_func    (alu_func),
    .alu_out     (alu_out),
    .alu_status  (alu_status),
    .flags       (flags),
    .done        (done),
    .result      (result),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Behavioural ALU: returns {status, out}.
  function automatic logic [23:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic imm, input logic [15:0] iv,
                                         input logic [3:0] f);
    logic [15:0] bs, o;
    bs = imm ? iv : b;
    case (f)
      4'd0:    o = bs;
      4'd1:    o = a - bs;
      4'd2:    o = a + bs;
      4'd3:    o = a & bs;
      4'd4:    o = a ^ bs;
      4'd5:    o = b | iv;
      4'd6:    o = a << bs[3:0];
      default: o = ~a;
    endcase
    return {(o == 16'h0), o[15], 2'b01, f, o};
  endfunction

  always_comb {alu_status, alu_out} = alu_fn(alu_a, alu_b, alu_imm, alu_imm_val, alu_func);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference state
  logic [15:0] mregs [8];
  logic [7:0]  mflags;
  logic [15:0] mresult;

  function automatic logic [15:0] mread(input logic [2:0] i);
    return (i == 3'd0) ? 16'h0 : mregs[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    mflags  = 8'h0;
    mresult = 16'h0;
  endtask

  int   cyc = 0;
  int   done_cyc[$];
  logic prev_done = 1'b0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      chk("done_single", 32'(prev_done), 32'd0);
      done_cyc.push_back(cyc);
    end
    prev_done = done;
  end

  // Entered just after a negedge; returns just after the negedge of the
  // cycle following writeback (sequencer idle again).
  task automatic run_op(input logic [3:0] f, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [2:0] rt, input logic imm, input logic [15:0] iv);
    logic [15:0] ea, eb;
    logic [23:0] r;
    int budget;
    bus.op_valid = 1'b1; bus.op_func = f; bus.op_rd = rd; bus.op_rs = rs;
    bus.op_rt = rt; bus.op_imm = imm; bus.op_imm_val = iv;
    budget = 0;
    while (bus.op_ready !== 1'b1 && budget < 10) begin
      @(negedge clk); #1;
      budget++;
    end
    chk("accept_ready", 32'(bus.op_ready), 32'd1);
    ea = mread(rs);
    eb = mread(rt);
    @(negedge clk); #1;
    bus.op_valid = 1'b0;
    bus.op_func = 4'($urandom); bus.op_rs = 3'($urandom); bus.op_rt = 3'($urandom);
    bus.op_imm_val = 16'($urandom); bus.op_imm = 1'($urandom);
    chk("exec_ready",   32'(bus.op_ready), 32'd0);
    chk("exec_done",    32'(done), 32'd0);
    chk("exec_a",       32'(alu_a), 32'(ea));
    chk("exec_b",       32'(alu_b), 32'(eb));
    chk("exec_func",    32'(alu_func), 32'(f));
    chk("exec_imm",     32'(alu_imm), 32'(imm));
    chk("exec_imm_val", 32'(alu_imm_val), 32'(iv));
    r = alu_fn(ea, eb, imm, iv, f);
    @(negedge clk); #1;
    chk("wb_done",   32'(done), 32'd1);
    chk("wb_ready",  32'(bus.op_ready), 32'd0);
    chk("wb_result_old", 32'(result), 32'(mresult));
    @(negedge clk); #1;
    if (rd != 3'd0) mregs[rd] = r[15:0];
    mresult = r[15:0];
    mflags  = r[23:16];
    chk("post_result", 32'(result), 32'(mresult));
    chk("post_flags",  32'(flags), 32'(mflags));
    chk("post_done",   32'(done), 32'd0);
    chk("post_ready",  32'(bus.op_ready), 32'd1);
    dbg_addr = rd; #1;
    chk("post_dbg_rd", 32'(dbg_data), 32'(mread(rd)));
  endtask

  initial begin
    logic [3:0]  acc;
    logic [23:0] r;
    int ph, n0;

    model_reset();
    dbg_addr = 3'd0;
    bus.op_valid = 1'b1; bus.op_func = 4'hA; bus.op_rd = 3'd1; bus.op_rs = 3'd2;
    bus.op_rt = 3'd3; bus.op_imm = 1'b1; bus.op_imm_val = 16'h5555;

    // Reset with op_valid held high
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(bus.op_ready), 32'd1);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_alu_func", 32'(alu_func), 32'd0);
    chk("rst_alu_imm_val", 32'(alu_imm_val), 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #0.5;
      chk("rst_dbg", 32'(dbg_data), 32'd0);
    end
    bus.op_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_no_accept", 32'(bus.op_ready), 32'd1);
    chk("rst_no_func",   32'(alu_func), 32'd0);

    // Back-to-back dependency
    run_op(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd4);
    run_op(4'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'd3);
    run_op(4'd2, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0);
    dbg_addr = 3'd3; #1;
    chk("b2b_r3", 32'(dbg_data), 32'd7);
    n0 = done_cyc.size();
    run_op(4'd7, 3'd5, 3'd3, 3'd0, 1'b0, 16'd0);
    if (done_cyc.size() >= 2)
      chk("b2b_gap", 32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 32'd3);
    chk("b2b_done_cnt", 32'(done_cyc.size() - n0), 32'd1);

    // Immediate build, high then low half
    run_op(4'd0, 3'd4, 3'd0, 3'd0, 1'b1, 16'h1200);
    dbg_addr = 3'd4; #1;
    chk("imm_r4", 32'(dbg_data), 32'h1200);
    run_op(4'd5, 3'd6, 3'd0, 3'd4, 1'b1, 16'h0034);
    dbg_addr = 3'd6; #1;
    chk("imm_r6", 32'(dbg_data), 32'h1234);

    // Register 0 as destination and source
    run_op(4'd3, 3'd0, 3'd1, 3'd2, 1'b0, 16'd0);
    dbg_addr = 3'd0; #1;
    chk("r0_dbg", 32'(dbg_data), 32'd0);
    run_op(4'd2, 3'd7, 3'd0, 3'd1, 1'b0, 16'd0);

    // Busy ignore: op_valid held with a changing function code
    bus.op_valid = 1'b1; bus.op_rd = 3'd0; bus.op_rs = 3'd1; bus.op_rt = 3'd2; bus.op_imm = 1'b0;
    ph = 0;
    acc = 4'd0;
    for (int k = 0; k < 12; k++) begin
      bus.op_func = 4'($urandom);
      chk("busy_ready", 32'(bus.op_ready), 32'(ph == 0));
      if (ph == 0) acc = bus.op_func;
      @(negedge clk); #1;
      ph = (ph + 1) % 3;
      chk("busy_func", 32'(alu_func), 32'(acc));
      chk("busy_done", 32'(done), 32'(ph == 2));
      if (ph == 0) begin
        r = alu_fn(mread(3'd1), mread(3'd2), 1'b0, bus.op_imm_val, acc);
        mresult = r[15:0];
        mflags  = r[23:16];
        chk("busy_result", 32'(result), 32'(mresult));
        chk("busy_flags",  32'(flags), 32'(mflags));
      end
    end
    bus.op_valid = 1'b0;

    // Randomized operations
    repeat (40) begin
      run_op(4'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
             1'($urandom), 16'($urandom));
    end

    // Reset in EXEC aborts the operation
    n0 = done_cyc.size();
    bus.op_valid = 1'b1; bus.op_func = 4'd0; bus.op_rd = 3'd6; bus.op_imm = 1'b1;
    bus.op_imm_val = 16'hBEEF;
    chk("mid_ready", 32'(bus.op_ready), 32'd1);
    @(negedge clk); #1;
    bus.op_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    chk("mid_done",  32'(done), 32'd0);
    chk("mid_ready_after", 32'(bus.op_ready), 32'd1);
    dbg_addr = 3'd6; #1;
    chk("mid_r6", 32'(dbg_data), 32'(mread(3'd6)));
    @(negedge clk); #1;
    chk("mid_done2",  32'(done), 32'd0);
    chk("mid_flags",  32'(flags), 32'(mflags));
    chk("mid_result", 32'(result), 32'(mresult));
    repeat (3) @(negedge clk);
    #1;
    chk("mid_no_done", 32'(done_cyc.size() - n0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
